operand_fetch: RTL and testbench

- Upstream stage of the action-signal logic.
- Accepts a decoded instruction (opcode plus two source addresses) through a valid/ready handshake.
- Fetches both operands from data memory over a request/valid read port, then presents opcode and operands with o_ALUOpReady and o_DataReady.
- Holds them until the downstream action strobe i_Action consumes them.

---
 rtl/operand_fetch_pkg.sv | 14 +
 rtl/operand_fetch_if.sv | 35 +++
 rtl/operand_fetch_wait_timer.sv | 19 +
 rtl/operand_fetch.sv | 86 ++++++++
 tb/tb_operand_fetch.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: default datapath widths and fetch FSM state encoding
package operand_fetch_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_OP_W = 4;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_A  = 3'd1,
    WAIT_A = 3'd2,
    REQ_B  = 3'd3,
    WAIT_B = 3'd4,
    READY  = 3'd5
  } state_t;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: instruction, memory read and operand/action signals of the fetch stage
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_W = DEF_OP_W
);
  logic              i_InstrValid;
  logic              o_InstrReady;
  logic [OP_W-1:0]   i_Opcode;
  logic [ADDR_W-1:0] i_AddrA;
  logic [ADDR_W-1:0] i_AddrB;
  logic              o_MemRd;
  logic [ADDR_W-1:0] o_MemAddr;
  logic              i_MemValid;
  logic [DATA_W-1:0] i_MemData;
  logic              o_ALUOpReady;
  logic              o_DataReady;
  logic [OP_W-1:0]   o_Opcode;
  logic [DATA_W-1:0] o_OperandA;
  logic [DATA_W-1:0] o_OperandB;
  logic              i_Action;
  logic              o_Error;
  modport slave (
    input  i_InstrValid, i_Opcode, i_AddrA, i_AddrB, i_MemValid, i_MemData, i_Action,
    output o_InstrReady, o_MemRd, o_MemAddr, o_ALUOpReady, o_DataReady, o_Opcode,
           o_OperandA, o_OperandB, o_Error
  );
  modport master (
    output i_InstrValid, i_Opcode, i_AddrA, i_AddrB, i_MemValid, i_MemData, i_Action,
    input  o_InstrReady, o_MemRd, o_MemAddr, o_ALUOpReady, o_DataReady, o_Opcode,
           o_OperandA, o_OperandB, o_Error
  );
endinterface

// File: rtl/operand_fetch_wait_timer.sv
// operand_fetch_wait_timer: memory wait counter; o_tc flags the last allowed wait cycle
module operand_fetch_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic i_Clk,
  input  logic i_nReset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge i_Clk or negedge i_nReset)
    if (!i_nReset) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  // High while this wait cycle's increment would reach MEM_TIMEOUT
  assign o_tc = r_cnt == CW'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: latches a decoded instruction, reads both operands from memory, holds them until i_Action
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int OP_W = DEF_OP_W,
  parameter int MEM_TIMEOUT = 15
) (
  input logic i_Clk,
  input logic i_nReset,
  operand_fetch_if.slave bus
);
  state_t            r_state, w_next;
  logic [OP_W-1:0]   r_opcode;
  logic [ADDR_W-1:0] r_addr_a, r_addr_b, r_mem_addr;
  logic [DATA_W-1:0] r_op_a, r_op_b;
  logic              r_err;
  logic              w_accept, w_same, w_clr, w_en, w_tc, w_timeout, w_cap_a, w_cap_b;
  assign w_accept = r_state == IDLE && bus.i_InstrValid;
  assign w_same = r_addr_a == r_addr_b;
  assign w_timeout = w_en && w_tc;
  operand_fetch_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .i_Clk(i_Clk),
    .i_nReset(i_nReset),
    .i_clr(w_clr),
    .i_en(w_en),
    .o_tc(w_tc)
  );
  always_comb begin
    w_next = r_state;
    w_clr = 1'b0;
    w_en = 1'b0;
    w_cap_a = 1'b0;
    w_cap_b = 1'b0;
    case (r_state)
      IDLE: w_next = bus.i_InstrValid ? REQ_A : IDLE;
      REQ_A, REQ_B: begin
        w_clr = 1'b1;
        w_next = r_state == REQ_A ? WAIT_A : WAIT_B;
      end
      WAIT_A, WAIT_B: begin
        // Equal source addresses share the single read of A
        w_cap_a = bus.i_MemValid && r_state == WAIT_A;
        w_cap_b = bus.i_MemValid && (r_state == WAIT_B || w_same);
        w_en = !bus.i_MemValid;
        w_next = bus.i_MemValid ? ((r_state == WAIT_A && !w_same) ? REQ_B : READY)
               : w_tc ? IDLE : r_state;
      end
      READY: w_next = bus.i_Action ? IDLE : READY;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_Clk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_state <= IDLE;
      r_opcode <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_mem_addr <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err <= w_timeout;
      if (w_accept) begin
        r_opcode <= bus.i_Opcode;
        r_addr_a <= bus.i_AddrA;
        r_addr_b <= bus.i_AddrB;
        r_mem_addr <= bus.i_AddrA;
      end else if (w_cap_a && !w_same) r_mem_addr <= r_addr_b;
      if (w_cap_a) r_op_a <= bus.i_MemData;
      if (w_cap_b) r_op_b <= bus.i_MemData;
    end
  end
  assign bus.o_InstrReady = r_state == IDLE;
  assign bus.o_MemRd = r_state == REQ_A || r_state == REQ_B;
  assign bus.o_MemAddr = r_mem_addr;
  assign bus.o_ALUOpReady = r_state != IDLE;
  assign bus.o_DataReady = r_state == READY;
  assign bus.o_Opcode = r_opcode;
  assign bus.o_OperandA = r_op_a;
  assign bus.o_OperandB = r_op_b;
  assign bus.o_Error = r_err;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: vector table plus scoreboard against a behavioural data memory
module tb_operand_fetch;
  import operand_fetch_pkg::*;
  typedef struct {
    logic [3:0] op;
    logic [7:0] aa, ab, ea, eb;
    int d, lat;
  } vec_t;
  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b;
    int lat, acc;
  } exp_t;
  logic i_Clk = 1'b0;
  logic i_nReset = 1'b0;
  int checks = 0, failures = 0, cyc = 0, err_cnt = 0, last_acc = 0;
  int mem_delay = 1, wait_left = -1;
  bit mem_never = 1'b0, stray = 1'b0, prev_dr = 1'b0;
  logic [7:0] pend_addr;
  logic [7:0] rd_log[$];
  exp_t sb[$];
  always #5 i_Clk = ~i_Clk;
  operand_fetch_if bus ();
  operand_fetch #(.MEM_TIMEOUT(15)) dut (.i_Clk(i_Clk), .i_nReset(i_nReset), .bus(bus));
  function automatic logic [7:0] mem_f(input logic [7:0] a);
    return a == 8'h10 ? 8'h5A : a == 8'h20 ? 8'hA5 : a == 8'h33 ? 8'h7E : a * 8'd7 + 8'd3;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(posedge i_Clk) cyc <= cyc + 1;
  // Data memory: answers each read request mem_delay cycles later
  always @(posedge i_Clk or negedge i_nReset) begin
    if (!i_nReset) begin
      wait_left = -1;
      bus.i_MemValid = 1'b0;
      bus.i_MemData = 8'h00;
    end else begin
      if (bus.o_MemRd) begin
        rd_log.push_back(bus.o_MemAddr);
        pend_addr = bus.o_MemAddr;
        wait_left = mem_never ? -1 : mem_delay - 1;
      end
      #1;
      if (wait_left == 0) begin
        bus.i_MemValid = 1'b1;
        bus.i_MemData = mem_f(pend_addr);
        wait_left = -1;
      end else begin
        if (wait_left > 0) wait_left--;
        bus.i_MemValid = stray;
        bus.i_MemData = 8'hEE;
      end
    end
  end
  always @(negedge i_Clk) begin
    exp_t e;
    if (bus.o_Error) err_cnt++;
    if (bus.o_DataReady && !prev_dr) begin
      if (sb.size() == 0) chk("unexpected_ready", 1, 0);
      else begin
        e = sb.pop_front();
        chk("opcode", bus.o_Opcode, e.op);
        chk("operand_a", bus.o_OperandA, e.a);
        chk("operand_b", bus.o_OperandB, e.b);
        chk("latency", cyc - e.acc, e.lat);
      end
    end
    prev_dr = bus.o_DataReady;
  end
  task automatic issue(input logic [3:0] op, input logic [7:0] aa, input logic [7:0] ab,
                       input int d, input bit push, input logic [7:0] ea, input logic [7:0] eb,
                       input int lat);
    exp_t e;
    int n = 0;
    @(negedge i_Clk);
    while (!bus.o_InstrReady && n < 50) begin
      @(negedge i_Clk);
      n++;
    end
    chk("instr_ready", bus.o_InstrReady, 1);
    mem_delay = d;
    bus.i_Opcode = op;
    bus.i_AddrA = aa;
    bus.i_AddrB = ab;
    bus.i_InstrValid = 1'b1;
    @(posedge i_Clk);
    #1;
    bus.i_InstrValid = 1'b0;
    last_acc = cyc - 1;
    e.op = op;
    e.a = ea;
    e.b = eb;
    e.lat = lat;
    e.acc = last_acc;
    if (push) sb.push_back(e);
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!bus.o_DataReady && n < 80) begin
      @(negedge i_Clk);
      n++;
    end
    chk("ready_wait", bus.o_DataReady, 1);
  endtask
  task automatic consume();
    bus.i_Action = 1'b1;
    @(posedge i_Clk);
    #1;
    bus.i_Action = 1'b0;
    @(negedge i_Clk);
    chk("cons_data_ready", bus.o_DataReady, 0);
    chk("cons_op_ready", bus.o_ALUOpReady, 0);
    chk("cons_instr_ready", bus.o_InstrReady, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[7];
    int n, lat, err_before;
    bit seen;
    tbl[0] = '{4'h3, 8'h10, 8'h20, 8'h5A, 8'hA5, 1, 5};
    tbl[1] = '{4'hA, 8'h33, 8'h33, 8'h7E, 8'h7E, 1, 3};
    tbl[2] = '{4'h5, 8'h10, 8'h20, 8'h5A, 8'hA5, 15, 33};
    tbl[3] = '{4'hF, 8'h01, 8'h02, 8'h0A, 8'h11, 2, 7};
    tbl[4] = '{4'h0, 8'hFF, 8'h00, 8'hFC, 8'h03, 3, 9};
    tbl[5] = '{4'h7, 8'h40, 8'h40, 8'hC3, 8'hC3, 4, 6};
    tbl[6] = '{4'hC, 8'h80, 8'h33, 8'h83, 8'h7E, 14, 31};
    bus.i_InstrValid = 1'b0;
    bus.i_Opcode = '0;
    bus.i_AddrA = '0;
    bus.i_AddrB = '0;
    bus.i_Action = 1'b0;
    repeat (2) @(negedge i_Clk);
    chk("rst_instr_ready", bus.o_InstrReady, 1);
    chk("rst_op_ready", bus.o_ALUOpReady, 0);
    chk("rst_data_ready", bus.o_DataReady, 0);
    chk("rst_mem_rd", bus.o_MemRd, 0);
    chk("rst_error", bus.o_Error, 0);
    chk("rst_opcode", bus.o_Opcode, 0);
    i_nReset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rd_log.delete();
      issue(tbl[i].op, tbl[i].aa, tbl[i].ab, tbl[i].d, 1'b1, tbl[i].ea, tbl[i].eb, tbl[i].lat);
      wait_ready();
      chk("rd_count", rd_log.size(), tbl[i].aa == tbl[i].ab ? 1 : 2);
      if (rd_log.size() > 0) chk("rd_addr_a", rd_log[0], tbl[i].aa);
      if (rd_log.size() > 1) chk("rd_addr_b", rd_log[1], tbl[i].ab);
      chk("mem_addr_hold", bus.o_MemAddr, tbl[i].ab);
      chk("op_ready_high", bus.o_ALUOpReady, 1);
      consume();
    end
    // Hold in READY with a pending instruction and stray memory strobes
    issue(4'h3, 8'h10, 8'h20, 1, 1'b1, 8'h5A, 8'hA5, 5);
    wait_ready();
    bus.i_Opcode = 4'h9;
    bus.i_AddrA = 8'h01;
    bus.i_AddrB = 8'h02;
    bus.i_InstrValid = 1'b1;
    stray = 1'b1;
    repeat (10) begin
      @(negedge i_Clk);
      chk("hold_data_ready", bus.o_DataReady, 1);
      chk("hold_instr_ready", bus.o_InstrReady, 0);
      chk("hold_opcode", bus.o_Opcode, 4'h3);
      chk("hold_operand_a", bus.o_OperandA, 8'h5A);
      chk("hold_operand_b", bus.o_OperandB, 8'hA5);
    end
    bus.i_InstrValid = 1'b0;
    stray = 1'b0;
    consume();
    // i_Action held through the whole fetch must not consume early
    bus.i_Action = 1'b1;
    issue(4'h2, 8'h01, 8'h02, 3, 1'b1, 8'h0A, 8'h11, 9);
    wait_ready();
    bus.i_Action = 1'b0;
    @(negedge i_Clk);
    chk("action_early_ignored", bus.o_DataReady, 1);
    consume();
    // Memory never answers the first read
    #1;
    err_before = err_cnt;
    mem_never = 1'b1;
    rd_log.delete();
    issue(4'h6, 8'h10, 8'h20, 1, 1'b0, 8'h00, 8'h00, 0);
    seen = 1'b0;
    lat = 0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge i_Clk);
      n++;
      if (bus.o_Error) begin
        seen = 1'b1;
        lat = cyc - last_acc;
      end
    end
    chk("timeout_error_seen", seen, 1);
    chk("timeout_cycle", lat, 17);
    chk("timeout_op_ready", bus.o_ALUOpReady, 0);
    chk("timeout_instr_ready", bus.o_InstrReady, 1);
    chk("timeout_rd_count", rd_log.size(), 1);
    @(negedge i_Clk);
    chk("timeout_pulse_width", bus.o_Error, 0);
    #1;
    chk("timeout_err_count", err_cnt - err_before, 1);
    mem_never = 1'b0;
    // Asynchronous reset while waiting for operand B
    err_before = err_cnt;
    rd_log.delete();
    issue(4'h9, 8'h01, 8'h02, 10, 1'b0, 8'h00, 8'h00, 0);
    n = 0;
    while (rd_log.size() < 2 && n < 40) begin
      @(negedge i_Clk);
      n++;
    end
    chk("reset_reached_wait_b", rd_log.size(), 2);
    repeat (3) @(negedge i_Clk);
    chk("pre_reset_operand_a", bus.o_OperandA, 8'h0A);
    #2;
    i_nReset = 1'b0;
    #1;
    chk("async_instr_ready", bus.o_InstrReady, 1);
    chk("async_op_ready", bus.o_ALUOpReady, 0);
    chk("async_data_ready", bus.o_DataReady, 0);
    chk("async_mem_rd", bus.o_MemRd, 0);
    chk("async_operand_a", bus.o_OperandA, 0);
    chk("async_opcode", bus.o_Opcode, 0);
    @(negedge i_Clk);
    i_nReset = 1'b1;
    repeat (3) @(negedge i_Clk);
    #1;
    chk("reset_no_error", err_cnt - err_before, 0);
    chk("reset_instr_ready", bus.o_InstrReady, 1);
    issue(4'h4, 8'h20, 8'h10, 1, 1'b1, 8'hA5, 8'h5A, 5);
    wait_ready();
    consume();
    repeat (3) @(negedge i_Clk);
    chk("sb_empty", sb.size(), 0);
    chk("total_errors", err_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
